// File: rtl/lfsr_req_arbiter.sv
// rtl/lfsr_req_arbiter.sv - two-requester round-robin arbiter sharing a 5-bit LFSR (optional macro: LFSR_LOCKUP_FIX_EN)

// 5-bit LFSR datapath: seed load, single-step advance, look-ahead of the next value
module lfsr_req_arbiter_lfsr5 #(
  parameter logic [4:0] SEED_RST = 5'b00001
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       load,
  input  logic [4:0] seed,
  input  logic       adv,
  output logic [4:0] q,
  output logic [4:0] q_next
);

  logic [4:0] seed_eff;

  // Successor of the current value; all-ones is a fixed point unless the lock-up fix is built in
  always_comb begin
    q_next    = 5'b00000;
    q_next[0] = q[4];
    q_next[1] = q[0];
    q_next[2] = q[1];
    q_next[3] = q[4] | q[2];
    q_next[4] = ~(q[4] ^ q[3]);
`ifdef LFSR_LOCKUP_FIX_EN
    if (q == 5'b11111) begin
      q_next = 5'b00001;
    end
`endif
  end

  // Seed as it will be stored; the lock-up value is replaced when the fix is built in
  always_comb begin
    seed_eff = seed;
`ifdef LFSR_LOCKUP_FIX_EN
    if (seed == 5'b11111) begin
      seed_eff = 5'b00001;
    end
`endif
  end

  // Shift register state: load wins over advance
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= SEED_RST;
    end else if (load) begin
      q <= seed_eff;
    end else if (adv) begin
      q <= q_next;
    end
  end

endmodule

// Arbiter top: picks a requester, advances the LFSR STEPS times, returns the word
module lfsr_req_arbiter #(
  parameter int         STEPS    = 3,
  parameter logic [4:0] SEED_RST = 5'b00001
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [1:0] req,
  input  logic       seed_vld,
  input  logic [4:0] seed,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [4:0] rnd,
  output logic       rnd_vld
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last;
  logic       owner;
  logic       pick;
  logic       lfsr_load;
  logic       lfsr_adv;
  logic [4:0] lfsr_q;
  logic [4:0] lfsr_next;

  // Seeds are only taken while idle; the register advances once per SHIFT cycle
  assign lfsr_load = (state == IDLE) && seed_vld;
  assign lfsr_adv  = (state == SHIFT);

  lfsr_req_arbiter_lfsr5 #(
    .SEED_RST (SEED_RST)
  ) u_lfsr (
    .clk    (clk),
    .rst_b  (rst_b),
    .load   (lfsr_load),
    .seed   (seed),
    .adv    (lfsr_adv),
    .q      (lfsr_q),
    .q_next (lfsr_next)
  );

  // Round-robin choice: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
  end

  // Transaction FSM with registered grant, busy and result outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last    <= 1'b1;
      owner   <= 1'b0;
      gnt     <= 2'b00;
      busy    <= 1'b0;
      rnd     <= 5'b00000;
      rnd_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rnd_vld <= 1'b0;
          if (!seed_vld && (req != 2'b00)) begin
            owner <= pick;
            cnt   <= 4'(STEPS);
            gnt   <= pick ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // The final advance lands in the register at this edge, so capture its look-ahead
            rnd     <= lfsr_next;
            rnd_vld <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          rnd_vld <= 1'b0;
          last    <= owner;
          gnt     <= 2'b00;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          gnt     <= 2'b00;
          busy    <= 1'b0;
          rnd_vld <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_req_arbiter.sv
// tb/tb_lfsr_req_arbiter.sv - scoreboard bench for lfsr_req_arbiter with a reference model
module tb_lfsr_req_arbiter;

  localparam int         STEPS    = 3;
  localparam logic [4:0] SEED_RST = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [1:0] req;
  logic       seed_vld;
  logic [4:0] seed;
  logic [1:0] gnt;
  logic       busy;
  logic [4:0] rnd;
  logic       rnd_vld;

  lfsr_req_arbiter #(
    .STEPS    (STEPS),
    .SEED_RST (SEED_RST)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .req      (req),
    .seed_vld (seed_vld),
    .seed     (seed),
    .gnt      (gnt),
    .busy     (busy),
    .rnd      (rnd),
    .rnd_vld  (rnd_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] gnt;
    logic [4:0] rnd;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic [4:0] m_lfsr;
  bit         m_last;

  function automatic logic [4:0] m_step(input logic [4:0] v);
    logic [4:0] n;
`ifdef LFSR_LOCKUP_FIX_EN
    if (v == 5'b11111) return 5'b00001;
`endif
    n = {~(v[4] ^ v[3]), v[4] | v[2], v[1], v[0], v[4]};
    return n;
  endfunction

  function automatic logic [4:0] m_seed(input logic [4:0] s);
`ifdef LFSR_LOCKUP_FIX_EN
    if (s == 5'b11111) return 5'b00001;
`endif
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: every result pulse is matched against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b === 1'b1 && rnd_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rnd_vld actual=1 required=0 t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("rnd", 32'(rnd), 32'(e.rnd));
          check("gnt_at_vld", 32'(gnt), 32'(e.gnt));
          check("latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] pat, input bit drop_early, input bit noise);
    exp_t e;
    int   own;
    int   n;
    if (pat == 2'b01)      own = 0;
    else if (pat == 2'b10) own = 1;
    else                   own = m_last ? 0 : 1;
    for (int i = 0; i < STEPS; i++) m_lfsr = m_step(m_lfsr);
    e.gnt = (own == 1) ? 2'b10 : 2'b01;
    e.rnd = m_lfsr;
    e.cyc = cyc + STEPS + 1;
    exp_q.push_back(e);
    m_last = (own == 1);
    req = pat;
    @(negedge clk);
    check("gnt_after_accept", 32'(gnt), 32'(e.gnt));
    check("busy_after_accept", 32'(busy), 32'd1);
    if (noise) begin
      seed_vld = 1'b1;
      seed     = 5'($urandom);
    end
    if (drop_early) req = 2'($urandom);
    n = 0;
    while (rnd_vld !== 1'b1 && n < 20) begin
      @(negedge clk);
      seed_vld = 1'b0;
      check("gnt_hold", 32'(gnt), 32'(e.gnt));
      check("busy_hold", 32'(busy), 32'd1);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL rnd_vld_timeout actual=0 required=1 t=%0t", $time);
    end
    req      = 2'b00;
    seed_vld = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_rnd_vld", 32'(rnd_vld), 32'd0);
  endtask

  task automatic do_seed(input logic [4:0] s, input bit with_req);
    seed_vld = 1'b1;
    seed     = s;
    req      = with_req ? 2'($urandom_range(1, 3)) : 2'b00;
    m_lfsr   = m_seed(s);
    @(negedge clk);
    seed_vld = 1'b0;
    req      = 2'b00;
    check("seed_no_grant_busy", 32'(busy), 32'd0);
    check("seed_no_grant_gnt", 32'(gnt), 32'd0);
  endtask

  task automatic do_async_reset();
    req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    #2 rst_b = 1'b0;
    req = 2'b00;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rnd_vld", 32'(rnd_vld), 32'd0);
    check("async_rst_rnd", 32'(rnd), 32'd0);
    #9 rst_b = 1'b1;
    m_lfsr = SEED_RST;
    m_last = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_b    = 1'b0;
    req      = 2'b00;
    seed_vld = 1'b0;
    seed     = 5'b00000;
    m_lfsr   = SEED_RST;
    m_last   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rnd_vld", 32'(rnd_vld), 32'd0);
    check("rst_rnd", 32'(rnd), 32'd0);
    rst_b = 1'b1;

    do_req(2'b01, 1'b0, 1'b0);
    do_req(2'b11, 1'b0, 1'b0);
    do_req(2'b11, 1'b0, 1'b0);
    do_req(2'b11, 1'b0, 1'b0);
    do_seed(5'b00001, 1'b1);
    do_req(2'b10, 1'b0, 1'b0);
    do_async_reset();
    do_req(2'b01, 1'b0, 1'b0);
    do_seed(5'b11111, 1'b0);
    do_req(2'b01, 1'b0, 1'b0);
    do_req(2'b01, 1'b1, 1'b1);
    do_req(2'b01, 1'b0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        do_seed(($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom), 1'($urandom));
      end else if (r <= 8) begin
        do_req(2'($urandom_range(1, 3)), 1'($urandom), 1'($urandom));
      end else begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
